iob_axi_crossbar_wr_route: RTL and testbench
============================================

Name: iob_axi_crossbar_wr_route

Overview:
Per-slave-interface write-data steering stage of the AXI crossbar. Sits directly downstream of the write-command output of the crossbar address decode/admission stage. Consumes one write command (select, decerr, id) per AW transaction and steers the matching W burst to the selected master port. On a decode error it drains the burst and generates a DECERR write response locally.

Parameters:
M_COUNT, 4, number of master (output) interfaces
DATA_WIDTH, 32, W data width in bits
STRB_WIDTH, DATA_WIDTH/8, W strobe width
ID_WIDTH, 8, AXI ID width
WUSER_ENABLE, 0, propagate wuser when 1
WUSER_WIDTH, 1, wuser width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_wc_select  in  $clog2(M_COUNT)  target master index
s_wc_decerr  in  1  command is a decode error
s_wc_id  in  ID_WIDTH  AWID of the transaction
s_wc_valid  in  1  command valid
s_wc_ready  out  1  command accepted
s_axi_wdata  in  DATA_WIDTH  slave W data
s_axi_wstrb  in  STRB_WIDTH  slave W strobes
s_axi_wlast  in  1  slave W last
s_axi_wuser  in  WUSER_WIDTH  slave W user
s_axi_wvalid  in  1  slave W valid
s_axi_wready  out  1  slave W ready
m_axi_wdata  out  DATA_WIDTH  shared W data to all masters
m_axi_wstrb  out  STRB_WIDTH  shared W strobes
m_axi_wlast  out  1  shared W last
m_axi_wuser  out  WUSER_WIDTH  shared W user (0 when WUSER_ENABLE=0)
m_axi_wvalid  out  M_COUNT  one-hot W valid per master
m_axi_wready  in  M_COUNT  W ready per master
m_decerr_bid  out  ID_WIDTH  ID for locally generated B response
m_decerr_bresp  out  2  constant 2'b11 (DECERR)
m_decerr_bvalid  out  1  local B response valid
m_decerr_bready  in  1  local B response ready

Behaviour:
- Single clock clk. Reset is synchronous and active-high on rst.
- States: IDLE, DATA, DRAIN, RESP. All are registered in state_reg; reset goes to IDLE.
- Reset values:
  - s_wc_ready=1 (IDLE).
  - s_axi_wready=0.
  - m_axi_wvalid=0.
  - m_decerr_bvalid=0.
  - m_decerr_bid=0.
  - select_reg=0.
- s_wc_ready is combinational and equals (state==IDLE).
- IDLE:
  - On s_wc_valid, latch select and id.
  - Go to DRAIN if s_wc_decerr, else go to DATA.
  - W channel is blocked: s_axi_wready=0, m_axi_wvalid=0.
- DATA, zero-latency combinational pass-through:
  - m_axi_wvalid[select_reg] = s_axi_wvalid; all other bits are 0.
  - s_axi_wready = m_axi_wready[select_reg].
  - wdata, wstrb, wlast and wuser are broadcast unchanged.
  - A beat transfers when s_axi_wvalid && s_axi_wready. If that beat has wlast=1, go to IDLE.
- DRAIN:
  - s_axi_wready=1 and m_axi_wvalid=0; beats are discarded.
  - A transferred beat with wlast=1 goes to RESP, registering m_decerr_bvalid=1 and m_decerr_bid=latched id.
- RESP:
  - Hold m_decerr_bvalid and bid stable until m_decerr_bready.
  - On the handshake, clear bvalid and go to IDLE.
  - s_axi_wready=0 in this state.
- Exactly one IDLE cycle separates consecutive bursts. The command handshake and the first W beat never occur in the same cycle.
- Valid is never deasserted without a handshake. m_axi_wvalid must not depend on m_axi_wready (AXI rule).
- Out-of-range select (select_reg >= M_COUNT when M_COUNT is not a power of 2) is treated as no target:
  - wvalid bits all 0.
  - s_axi_wready=0.
  - The address stage guarantees this never occurs; the bench asserts it.
- Burst length is not checked; wlast alone terminates a burst.
- Reset mid-burst: go immediately to IDLE and deassert all valids/readies as above. The partial burst is abandoned.
- WUSER_ENABLE=0: m_axi_wuser is driven to 0.

Decomposition:
- Shared crossbar package holds:
  - AXI resp encodings (OKAY=2'b00, DECERR=2'b11).
  - State encoding constants (IDLE/DATA/DRAIN/RESP).
  - The clog2-of-count width helper.
- No sub-module is needed. The local B generator is small enough to stay inline; it is later merged with master B responses by the crossbar's B mux.

Test Plan:
- Command select=2, decerr=0, then 4 beats (data 0x11..0x44, last on 4th), m_axi_wready=4'b0100 -> m_axi_wvalid=4'b0100 for each beat; data passes unchanged; back to IDLE after beat 4; s_wc_ready=1 the next cycle.
- Backpressure: select=1, m_axi_wready[1] toggles 1,0,0,1 -> s_axi_wready mirrors it; wdata held stable while stalled; no beats lost or duplicated.
- Decode error: decerr=1, id=0x5A, 3 beats -> s_axi_wready=1 with m_axi_wvalid=0 throughout; after last, m_decerr_bvalid=1, bid=0x5A, bresp=2'b11; bvalid held through 3 cycles of bready=0; cleared on handshake.
- Back-to-back commands (select 0 then select 3, single-beat bursts) -> second command accepted exactly one cycle after first wlast; each beat reaches only its own master.
- Reset asserted on the 2nd beat of a 4-beat burst -> next cycle: state IDLE, m_axi_wvalid=0, s_axi_wready=0, s_wc_ready=1; a new command is then accepted normally.
- Single-beat burst with wlast on beat 1 and wready=1 -> one-cycle DATA state, then IDLE.

Source files
------------

// File: rtl/iob_axi_crossbar_wr_route_pkg.sv
// Shared crossbar definitions: AXI response codes, write-route FSM states and a width helper.
package iob_axi_crossbar_wr_route_pkg;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespDecerr = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StData  = 2'd1,
        StDrain = 2'd2,
        StResp  = 2'd3
    } wr_state_e;

    // Index width for a port count; never returns 0 so single-port builds stay legal.
    function automatic int unsigned cnt_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/iob_axi_crossbar_wr_route_if.sv
// Bundle of the write-command, slave W, master W and local B signals of one write-route stage.
interface iob_axi_crossbar_wr_route_if
    import iob_axi_crossbar_wr_route_pkg::*;
#(
    parameter int unsigned M_COUNT     = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH    = 8,
    parameter int unsigned WUSER_WIDTH = 1
);
    localparam int unsigned SelWidth = cnt_width(M_COUNT);

    logic [SelWidth-1:0]    s_wc_select;
    logic                   s_wc_decerr;
    logic [ID_WIDTH-1:0]    s_wc_id;
    logic                   s_wc_valid;
    logic                   s_wc_ready;

    logic [DATA_WIDTH-1:0]  s_axi_wdata;
    logic [STRB_WIDTH-1:0]  s_axi_wstrb;
    logic                   s_axi_wlast;
    logic [WUSER_WIDTH-1:0] s_axi_wuser;
    logic                   s_axi_wvalid;
    logic                   s_axi_wready;

    logic [DATA_WIDTH-1:0]  m_axi_wdata;
    logic [STRB_WIDTH-1:0]  m_axi_wstrb;
    logic                   m_axi_wlast;
    logic [WUSER_WIDTH-1:0] m_axi_wuser;
    logic [M_COUNT-1:0]     m_axi_wvalid;
    logic [M_COUNT-1:0]     m_axi_wready;

    logic [ID_WIDTH-1:0]    m_decerr_bid;
    logic [1:0]             m_decerr_bresp;
    logic                   m_decerr_bvalid;
    logic                   m_decerr_bready;

    // Router side.
    modport slave (
        input  s_wc_select, s_wc_decerr, s_wc_id, s_wc_valid,
        output s_wc_ready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wuser, s_axi_wvalid,
        output s_axi_wready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser, m_axi_wvalid,
        input  m_axi_wready,
        output m_decerr_bid, m_decerr_bresp, m_decerr_bvalid,
        input  m_decerr_bready
    );

    // Surrounding crossbar side.
    modport master (
        output s_wc_select, s_wc_decerr, s_wc_id, s_wc_valid,
        input  s_wc_ready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wuser, s_axi_wvalid,
        input  s_axi_wready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser, m_axi_wvalid,
        output m_axi_wready,
        input  m_decerr_bid, m_decerr_bresp, m_decerr_bvalid,
        output m_decerr_bready
    );

endinterface

// File: rtl/iob_axi_crossbar_wr_route.sv
// Steers each W burst to the master chosen by its write command; decode-error bursts are
// drained here and answered with a locally generated DECERR B response.
module iob_axi_crossbar_wr_route
    import iob_axi_crossbar_wr_route_pkg::*;
#(
    parameter int unsigned M_COUNT      = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH     = 8,
    parameter int unsigned WUSER_ENABLE = 0,
    parameter int unsigned WUSER_WIDTH  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    iob_axi_crossbar_wr_route_if.slave  bus
);

    localparam int unsigned SelWidth = cnt_width(M_COUNT);

    wr_state_e             state_q, state_d;
    logic [SelWidth-1:0]   select_q, select_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic                  bvalid_q, bvalid_d;

    logic [M_COUNT-1:0]    sel_onehot;
    logic                  sel_wready;
    logic [M_COUNT-1:0]    w_valid;
    logic                  w_ready;

    // An out-of-range select matches no bit, so it routes nowhere and never grants ready.
    always_comb begin
        sel_onehot = '0;
        sel_wready = 1'b0;
        for (int i = 0; i < int'(M_COUNT); i++) begin
            if (int'(select_q) == i) begin
                sel_onehot[i] = 1'b1;
                sel_wready    = bus.m_axi_wready[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        id_d     = id_q;
        bid_d    = bid_q;
        bvalid_d = bvalid_q;
        w_valid  = '0;
        w_ready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.s_wc_valid) begin
                    select_d = bus.s_wc_select;
                    id_d     = bus.s_wc_id;
                    state_d  = bus.s_wc_decerr ? StDrain : StData;
                end
            end
            StData: begin
                // wvalid is derived from the slave valid only, never from master ready.
                w_valid = bus.s_axi_wvalid ? sel_onehot : '0;
                w_ready = sel_wready;
                if (bus.s_axi_wvalid && sel_wready && bus.s_axi_wlast) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                w_ready = 1'b1;
                if (bus.s_axi_wvalid && bus.s_axi_wlast) begin
                    bvalid_d = 1'b1;
                    bid_d    = id_q;
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (bus.m_decerr_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            select_q <= '0;
            id_q     <= '0;
            bid_q    <= '0;
            bvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            id_q     <= id_d;
            bid_q    <= bid_d;
            bvalid_q <= bvalid_d;
        end
    end

    assign bus.s_wc_ready      = (state_q == StIdle);
    assign bus.s_axi_wready    = w_ready;
    assign bus.m_axi_wvalid    = w_valid;
    assign bus.m_axi_wdata     = bus.s_axi_wdata;
    assign bus.m_axi_wstrb     = bus.s_axi_wstrb;
    assign bus.m_axi_wlast     = bus.s_axi_wlast;
    assign bus.m_decerr_bid    = bid_q;
    assign bus.m_decerr_bresp  = RespDecerr;
    assign bus.m_decerr_bvalid = bvalid_q;

    if (WUSER_ENABLE != 0) begin : g_wuser
        assign bus.m_axi_wuser = bus.s_axi_wuser;
    end else begin : g_no_wuser
        logic unused_wuser;
        assign unused_wuser    = ^bus.s_axi_wuser;
        assign bus.m_axi_wuser = '0;
    end

endmodule

// File: tb/tb_iob_axi_crossbar_wr_route.sv
// Directed scenarios followed by randomized bursts scored against per-master expected-beat queues.
module tb_iob_axi_crossbar_wr_route;

    localparam int unsigned MCount     = 4;
    localparam int unsigned DataWidth  = 32;
    localparam int unsigned StrbWidth  = 4;
    localparam int unsigned IdWidth    = 8;
    localparam int unsigned WuserWidth = 1;

    typedef logic [DataWidth+StrbWidth:0] beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    iob_axi_crossbar_wr_route_if #(
        .M_COUNT    (MCount),
        .DATA_WIDTH (DataWidth),
        .STRB_WIDTH (StrbWidth),
        .ID_WIDTH   (IdWidth),
        .WUSER_WIDTH(WuserWidth)
    ) bus ();

    iob_axi_crossbar_wr_route #(
        .M_COUNT     (MCount),
        .DATA_WIDTH  (DataWidth),
        .STRB_WIDTH  (StrbWidth),
        .ID_WIDTH    (IdWidth),
        .WUSER_ENABLE(0),
        .WUSER_WIDTH (WuserWidth)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    bit                 mon_en   = 1'b0;
    bit                 rand_rdy = 1'b0;
    beat_t              exp_q[MCount][$];
    logic [IdWidth-1:0] exp_bid_q[$];
    int                 exp_drain  = 0;
    int                 seen_drain = 0;
    int                 xfer_cnt[MCount];
    logic               prev_bvalid = 1'b0;
    logic               prev_bready = 1'b0;
    logic [IdWidth-1:0] prev_bid    = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int sel, input bit dec, input logic [IdWidth-1:0] id,
                            output int waited);
        int n = 0;
        bus.s_wc_valid  = 1'b1;
        bus.s_wc_select = 2'(sel);
        bus.s_wc_decerr = dec;
        bus.s_wc_id     = id;
        @(negedge clk);
        while (!bus.s_wc_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept_timeout", 64'(n < 100), 64'(1));
        waited = n;
        tick();
        bus.s_wc_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [DataWidth-1:0] d, input logic [StrbWidth-1:0] s,
                             input bit last);
        int n = 0;
        bus.s_axi_wvalid = 1'b1;
        bus.s_axi_wdata  = d;
        bus.s_axi_wstrb  = s;
        bus.s_axi_wlast  = last;
        bus.s_axi_wuser  = 1'($urandom);
        @(negedge clk);
        while (!bus.s_axi_wready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("beat_accept_timeout", 64'(n < 200), 64'(1));
        tick();
        bus.s_axi_wvalid = 1'b0;
    endtask

    task automatic run_burst(input int sel, input bit dec, input logic [IdWidth-1:0] id,
                             input int len);
        logic [DataWidth-1:0] d[4];
        logic [StrbWidth-1:0] s[4];
        int w;
        for (int k = 0; k < len; k++) begin
            d[k] = $urandom;
            s[k] = 4'($urandom);
            if (dec) exp_drain++;
            else     exp_q[sel].push_back({d[k], s[k], 1'(k == len - 1)});
        end
        if (dec) exp_bid_q.push_back(id);
        send_cmd(sel, dec, id, w);
        for (int k = 0; k < len; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_beat(d[k], s[k], k == len - 1);
        end
    endtask

    // Randomized master and B backpressure for the scored phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                bus.m_axi_wready    = 4'($urandom);
                bus.m_decerr_bready = 1'($urandom);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(MCount); i++) begin
                if (bus.m_axi_wvalid[i] && bus.m_axi_wready[i]) begin
                    xfer_cnt[i]++;
                    if (mon_en) begin
                        check($sformatf("beat_expected_m%0d", i),
                              64'(exp_q[i].size() != 0), 64'(1));
                        if (exp_q[i].size() != 0)
                            check($sformatf("beat_m%0d", i),
                                  64'({bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wlast}),
                                  64'(exp_q[i].pop_front()));
                    end
                end
            end
            if (mon_en) begin
                if (bus.s_axi_wvalid && bus.s_axi_wready && bus.m_axi_wvalid == '0)
                    seen_drain++;
                if (bus.m_decerr_bvalid && bus.m_decerr_bready) begin
                    check("b_expected", 64'(exp_bid_q.size() != 0), 64'(1));
                    if (exp_bid_q.size() != 0)
                        check("b_id_resp", 64'({bus.m_decerr_bid, bus.m_decerr_bresp}),
                              64'({exp_bid_q.pop_front(), 2'b11}));
                end
                if (prev_bvalid && !prev_bready)
                    check("b_hold", 64'({bus.m_decerr_bvalid, bus.m_decerr_bid}),
                          64'({1'b1, prev_bid}));
                if (bus.s_wc_ready)
                    check("idle_w_blocked", 64'({bus.s_axi_wready, bus.m_axi_wvalid}), 64'(0));
                check("wvalid_onehot0", 64'($onehot0(bus.m_axi_wvalid)), 64'(1));
                if (bus.s_axi_wvalid)
                    check("w_broadcast",
                          64'({bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wlast}),
                          64'({bus.s_axi_wdata, bus.s_axi_wstrb, bus.s_axi_wlast}));
                check("wuser_zero", 64'(bus.m_axi_wuser), 64'(0));
            end
            prev_bvalid = bus.m_decerr_bvalid;
            prev_bready = bus.m_decerr_bready;
            prev_bid    = bus.m_decerr_bid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w;
        int x0;
        int rdy_pat[4] = '{1, 0, 0, 1};
        int cur;
        int n;
        logic [DataWidth-1:0] bp_data[2] = '{32'hA0A0_0001, 32'hB0B0_0002};

        for (int i = 0; i < int'(MCount); i++) xfer_cnt[i] = 0;
        bus.s_wc_valid      = 1'b0;
        bus.s_wc_select     = '0;
        bus.s_wc_decerr     = 1'b0;
        bus.s_wc_id         = '0;
        bus.s_axi_wvalid    = 1'b0;
        bus.s_axi_wdata     = '0;
        bus.s_axi_wstrb     = '0;
        bus.s_axi_wlast     = 1'b0;
        bus.s_axi_wuser     = '0;
        bus.m_axi_wready    = '0;
        bus.m_decerr_bready = 1'b0;

        // Reset values.
        repeat (2) tick();
        @(negedge clk);
        check("rst_wc_ready", 64'(bus.s_wc_ready), 64'(1));
        check("rst_outputs", 64'({bus.s_axi_wready, bus.m_axi_wvalid, bus.m_decerr_bvalid}),
              64'(0));
        check("rst_bid_bresp", 64'({bus.m_decerr_bid, bus.m_decerr_bresp}), 64'({8'h00, 2'b11}));
        tick();
        rst = 1'b0;

        // 4-beat burst to master 2; first beat is already offered during the command cycle.
        bus.m_axi_wready = 4'b0100;
        bus.s_wc_valid   = 1'b1;
        bus.s_wc_select  = 2'd2;
        bus.s_wc_decerr  = 1'b0;
        bus.s_wc_id      = 8'h12;
        bus.s_axi_wvalid = 1'b1;
        bus.s_axi_wdata  = 32'h11;
        bus.s_axi_wstrb  = 4'hF;
        bus.s_axi_wlast  = 1'b0;
        @(negedge clk);
        check("t1_cmd_ready", 64'(bus.s_wc_ready), 64'(1));
        check("t1_no_beat_with_cmd", 64'({bus.s_axi_wready, bus.m_axi_wvalid}), 64'(0));
        tick();
        bus.s_wc_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.s_axi_wdata = 32'h11 * (k + 1);
            bus.s_axi_wlast = (k == 3);
            @(negedge clk);
            check($sformatf("t1_wvalid_b%0d", k), 64'(bus.m_axi_wvalid), 64'(4'b0100));
            check($sformatf("t1_wdata_b%0d", k), 64'(bus.m_axi_wdata), 64'(32'h11 * (k + 1)));
            check($sformatf("t1_wready_b%0d", k), 64'(bus.s_axi_wready), 64'(1));
            tick();
        end
        bus.s_axi_wvalid = 1'b0;
        @(negedge clk);
        check("t1_idle_after_last", 64'(bus.s_wc_ready), 64'(1));

        // Backpressure on master 1: ready pattern 1,0,0,1 over two beats.
        tick();
        send_cmd(1, 1'b0, 8'h21, w);
        x0  = xfer_cnt[1];
        cur = 0;
        for (int c = 0; c < 4; c++) begin
            bus.m_axi_wready = (rdy_pat[c] != 0) ? 4'b0010 : 4'b0000;
            bus.s_axi_wvalid = 1'b1;
            bus.s_axi_wdata  = bp_data[cur];
            bus.s_axi_wlast  = (cur == 1);
            @(negedge clk);
            check($sformatf("t2_wready_c%0d", c), 64'(bus.s_axi_wready), 64'(rdy_pat[c]));
            check($sformatf("t2_wdata_c%0d", c), 64'(bus.m_axi_wdata), 64'(bp_data[cur]));
            tick();
            if (rdy_pat[c] != 0) cur++;
        end
        bus.s_axi_wvalid = 1'b0;
        @(negedge clk);
        check("t2_beat_count", 64'(xfer_cnt[1] - x0), 64'(2));
        check("t2_idle", 64'(bus.s_wc_ready), 64'(1));

        // Decode error: drained burst, local DECERR response held under backpressure.
        tick();
        bus.m_axi_wready    = 4'b1111;
        bus.m_decerr_bready = 1'b0;
        send_cmd(3, 1'b1, 8'h5A, w);
        for (int k = 0; k < 3; k++) begin
            bus.s_axi_wvalid = 1'b1;
            bus.s_axi_wdata  = 32'hD0 + k;
            bus.s_axi_wlast  = (k == 2);
            @(negedge clk);
            check($sformatf("t3_drain_b%0d", k), 64'({bus.s_axi_wready, bus.m_axi_wvalid}),
                  64'(5'b10000));
            tick();
        end
        bus.s_axi_wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("t3_b_c%0d", c),
                  64'({bus.m_decerr_bvalid, bus.m_decerr_bid, bus.m_decerr_bresp}),
                  64'({1'b1, 8'h5A, 2'b11}));
            check($sformatf("t3_resp_wready_c%0d", c), 64'(bus.s_axi_wready), 64'(0));
            tick();
        end
        bus.m_decerr_bready = 1'b1;
        @(negedge clk);
        check("t3_b_at_hs", 64'(bus.m_decerr_bvalid), 64'(1));
        tick();
        bus.m_decerr_bready = 1'b0;
        @(negedge clk);
        check("t3_b_cleared", 64'({bus.m_decerr_bvalid, bus.s_wc_ready}), 64'(2'b01));

        // Back-to-back single-beat bursts to masters 0 and 3.
        tick();
        send_cmd(0, 1'b0, 8'h01, w);
        bus.s_axi_wvalid = 1'b1;
        bus.s_axi_wdata  = 32'hC0;
        bus.s_axi_wlast  = 1'b1;
        @(negedge clk);
        check("t4_wvalid_m0", 64'(bus.m_axi_wvalid), 64'(4'b0001));
        tick();
        bus.s_axi_wvalid = 1'b0;
        send_cmd(3, 1'b0, 8'h03, w);
        check("t4_b2b_accept_wait", 64'(w), 64'(0));
        bus.s_axi_wvalid = 1'b1;
        bus.s_axi_wdata  = 32'hC3;
        @(negedge clk);
        check("t4_wvalid_m3", 64'(bus.m_axi_wvalid), 64'(4'b1000));
        tick();
        bus.s_axi_wvalid = 1'b0;
        @(negedge clk);
        check("t4_single_beat_idle", 64'(bus.s_wc_ready), 64'(1));

        // Reset on the second beat of a 4-beat burst.
        tick();
        bus.m_axi_wready = 4'b0100;
        send_cmd(2, 1'b0, 8'h33, w);
        bus.s_axi_wvalid = 1'b1;
        bus.s_axi_wdata  = 32'h1;
        bus.s_axi_wlast  = 1'b0;
        tick();
        bus.s_axi_wdata = 32'h2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_after_rst", 64'({bus.s_wc_ready, bus.s_axi_wready, bus.m_axi_wvalid}),
              64'(6'b100000));
        tick();
        bus.m_axi_wready = 4'b0010;
        bus.s_axi_wdata  = 32'h3;
        bus.s_axi_wlast  = 1'b1;
        send_cmd(1, 1'b0, 8'h44, w);
        @(negedge clk);
        check("t5_new_burst", 64'({bus.m_axi_wvalid, bus.s_axi_wready}), 64'(5'b00101));
        tick();
        bus.s_axi_wvalid = 1'b0;
        bus.s_axi_wlast  = 1'b0;

        // Randomized bursts scored by the monitor.
        tick();
        mon_en   = 1'b1;
        rand_rdy = 1'b1;
        for (int b = 0; b < 40; b++) begin
            run_burst($urandom_range(0, 3), $urandom_range(0, 4) == 0, 8'($urandom),
                      $urandom_range(1, 4));
        end
        n = 0;
        @(negedge clk);
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() +
                exp_bid_q.size() != 0 || !bus.s_wc_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rand_complete_timeout", 64'(n < 500), 64'(1));
        check("rand_drained_beats", 64'(seen_drain), 64'(exp_drain));
        for (int i = 0; i < int'(MCount); i++)
            check($sformatf("rand_left_m%0d", i), 64'(exp_q[i].size()), 64'(0));
        check("rand_left_b", 64'(exp_bid_q.size()), 64'(0));
        mon_en   = 1'b0;
        rand_rdy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
